// File: rtl/mul_sequencer.sv
// Multi-cycle radix-2 shift-add multiplier for MUL/MULH in the EX stage.
// It stalls the pipeline while it works and strobes the product for one cycle.
module mul_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    input  logic [3:0]      i_alu_ctrl,
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    input  logic            i_flush,
    output logic            o_stall,
    output logic [XLEN-1:0] o_result,
    output logic            o_result_valid,
    output logic [1:0]      o_state
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_op_hi;
    logic              r_neg;
    logic [2*XLEN-1:0] r_acc;
    logic [2*XLEN-1:0] r_mcand;
    logic [XLEN-1:0]   r_mplier;
    logic [XLEN-1:0]   r_result;
    logic              r_result_valid;
    logic [CW-1:0]     r_count;

    logic              w_hi;
    logic              w_start;
    logic              w_sa;
    logic              w_sb;
    logic              w_zero;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic [2*XLEN-1:0] w_fixed;

    // Handshake: a multiply is accepted only from IDLE; the EX stage keeps the
    // instruction presented while o_stall=1 and advances on the o_result_valid cycle.
    assign w_hi    = (i_alu_ctrl == 4'b0101);
    assign w_start = i_valid && ((i_alu_ctrl == 4'b0100) || w_hi) &&
                     (r_state == S_IDLE) && !i_flush;
    assign w_sa    = i_op_a[XLEN-1] & w_hi;
    assign w_sb    = i_op_b[XLEN-1] & w_hi;
    assign w_mag_a = w_sa ? (~i_op_a + 1'b1) : i_op_a;
    assign w_mag_b = w_sb ? (~i_op_b + 1'b1) : i_op_b;
    assign w_zero  = (i_op_a == '0) || (i_op_b == '0);
    assign w_fixed = r_neg ? (~r_acc + 1'b1) : r_acc;

    assign o_stall        = w_start || (r_state == S_CALC) || (r_state == S_FIX);
    assign o_result       = r_result;
    assign o_result_valid = r_result_valid;
    assign o_state        = r_state;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_op_hi        <= 1'b0;
            r_neg          <= 1'b0;
            r_acc          <= '0;
            r_mcand        <= '0;
            r_mplier       <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_count        <= '0;
        end else if (i_flush) begin
            r_state        <= S_IDLE;
            r_result_valid <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_op_hi  <= w_hi;
                        r_neg    <= w_sa ^ w_sb;
                        r_mcand  <= {{XLEN{1'b0}}, w_mag_a};
                        r_mplier <= w_mag_b;
                        r_acc    <= '0;
                        r_count  <= '0;
                        // A zero operand needs no iterations; the product is zero.
                        if (w_zero) begin
                            r_result       <= '0;
                            r_result_valid <= 1'b1;
                            r_state        <= S_DONE;
                        end else begin
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + 1'b1;
                    if (r_count == CW'(XLEN - 1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_acc          <= w_fixed;
                    r_result       <= r_op_hi ? w_fixed[2*XLEN-1:XLEN] : w_fixed[XLEN-1:0];
                    r_result_valid <= 1'b1;
                    r_state        <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Multi-cycle sequencer for the EX-stage multiply operations (alu_ctrl 4'b0100 MUL, 4'b0101 MULH) of the RISC-V core. It accepts operands from the EX stage, runs a radix-2 shift-add multiplication over successive cycles, and holds the pipeline with a stall until the product is ready. Single-cycle ALU operations bypass it untouched. Its result is muxed onto the EX writeback path in place of the ALU result.

## Interface
- XLEN, 32, operand/result width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- valid  in  1  EX-stage instruction valid
- alu_ctrl  in  4  ALU control code from the ALU decoder
- op_a  in  XLEN  rs1 operand
- op_b  in  XLEN  rs2 operand
- flush  in  1  synchronous abort (branch mispredict/trap); overrides everything except rst
- stall  out  1  hold IF/ID/EX registers
- result  out  XLEN  product word; valid only while result_valid=1
- result_valid  out  1  one-cycle strobe; EX selects result over ALU output

## Operation
- start = valid && (alu_ctrl==4'b0100 || alu_ctrl==4'b0101) && state==IDLE && !flush.
- Any other alu_ctrl value: no action, stall=0.
- States: IDLE, CALC, FIX, DONE.
- IDLE: on start, latch op_hi = (alu_ctrl==4'b0101), signs sa=op_a[XLEN-1]&op_hi, sb=op_b[XLEN-1]&op_hi, magnitudes |op_a|, |op_b| (two's-complement negate when sign set; MUL treats operands unsigned, low word identical), clear 2*XLEN accumulator, count=0.
  - If op_a==0 or op_b==0 at start: go directly to DONE with product 0 (zero shortcut).
  - Otherwise go to CALC.
- CALC: each cycle, if multiplier LSB=1 add multiplicand into accumulator (2*XLEN wide, no overflow possible); shift multiplicand left 1, multiplier right 1; count++. After XLEN iterations (count==XLEN-1 this cycle) go to FIX.
- FIX: if sa^sb, negate full 2*XLEN product; go to DONE.
- DONE: result = op_hi ? product[2*XLEN-1:XLEN] : product[XLEN-1:0]; result_valid=1; stall=0; next state IDLE.
- The same instruction is still presented during DONE; it must not restart. The pipeline advances on the DONE edge.
- stall = start || state==CALC || state==FIX.
- flush in any state: next state IDLE, result_valid=0 next cycle, accumulator contents don't-care. If flush is asserted in DONE, the strobe in that cycle is still driven but is discarded by the pipeline.
- rst: state IDLE, count=0, accumulator=0, result=0, result_valid=0, stall=0.
- rst has priority over flush, which has priority over start.

## Timing
- Cycle T: start is seen; stall=1 combinationally in T.
- Normal path:
  - T+1..T+XLEN: CALC (32 cycles).
  - T+XLEN+1: FIX.
  - T+XLEN+2: DONE, result_valid=1, stall=0.
  - Latency 34 cycles for XLEN=32; stall is high for cycles T..T+33.
- Zero shortcut: DONE at T+1; stall high only in T.
- Back-to-back multiplies: the next start is accepted at the earliest in the cycle after DONE, since the state is IDLE then.
- result and result_valid are registered/state-decoded, with no combinational path from op_a/op_b.
- stall has a combinational path from valid/alu_ctrl in IDLE only.

## Test plan
- MUL 7×6: alu_ctrl=0100, op_a=7, op_b=6 at T -> stall 1 for T..T+33; result=0x0000002A, result_valid=1 at T+34 only.
- MULH signed extremes:
  - op_a=op_b=0x80000000 -> result=0x40000000.
  - op_a=0xFFFFFFFF, op_b=1 -> result=0xFFFFFFFF.
  - MUL with op_a=op_b=0xFFFFFFFF -> result=0x00000001.
- Zero shortcut: MULH op_a=0, op_b=0x12345678 -> stall only at T; result=0, result_valid=1 at T+1.
- Non-multiply passthrough: alu_ctrl=0010, valid=1 -> stall=0 and result_valid=0 for 40 cycles.
- Flush mid-CALC: assert flush at T+10 -> IDLE at T+11, no result_valid strobe, stall=0 from T+11; a new MUL 3×5 at T+12 returns 15 at T+46.
- Reset mid-FIX: rst=1 at T+33 -> at T+34 all outputs 0, state IDLE; after release, MUL 2×2 returns 4 at 34-cycle latency.
